// File: rtl/smem_pkg.sv
// Shared definitions for the shared-memory warp sequencer: lane geometry,
// watchdog limit and FSM state encoding.
// Optional feature macro: SMEM_WATCHDOG_EN (WAIT-state watchdog abort).
package smem_pkg;

  localparam int LANES       = 16;
  localparam int ADDR_W      = 12;
  localparam int DATA_W      = 8;
  localparam int BANK_BITS   = 4;
  localparam int WDOG_CYCLES = 255;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // True when at least one lane in the vector still needs service
  function automatic logic any_lane(input logic [LANES-1:0] lanes);
    return |lanes;
  endfunction

endpackage

// File: rtl/smem_lane_tracker.sv
// One lane of the warp sequencer: remembers whether the lane still owes a
// bank access, gates its read/write level, and captures its load byte.
// A finishing lane is masked in the same cycle so it is never serviced twice.
module smem_lane_tracker
  import smem_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              accept,
  input  logic              lane_en,
  input  logic              is_write,
  input  logic              in_wait,
  input  logic              abort,
  input  logic              finish,
  input  logic [DATA_W-1:0] rdata,
  output logic              pending,
  output logic              read_level,
  output logic              write_level,
  output logic [DATA_W-1:0] captured
);

  logic              pending_r;
  logic [DATA_W-1:0] captured_r;
  logic              live_s;

  // Pending bit and load-byte capture; a finish with no pending access is ignored
  always_ff @(posedge clock) begin
    if (reset) begin
      pending_r  <= 1'b0;
      captured_r <= {DATA_W{1'b0}};
    end else if (accept) begin
      pending_r  <= lane_en;
      captured_r <= {DATA_W{1'b0}};
    end else if (in_wait && pending_r && (finish || abort)) begin
      pending_r <= 1'b0;
      if (finish && !is_write) begin
        captured_r <= rdata;
      end else begin
        captured_r <= captured_r;
      end
    end else begin
      pending_r  <= pending_r;
      captured_r <= captured_r;
    end
  end

  assign live_s      = in_wait & pending_r & ~finish;
  assign read_level  = live_s & ~is_write;
  assign write_level = live_s & is_write;
  assign pending     = pending_r;
  assign captured    = captured_r;

endmodule

// File: rtl/smem_warp_sequencer.sv
// Warp-wide shared-memory access sequencer. Accepts one request, holds each
// active lane's read/write level until that lane's finish pulse, gathers
// load bytes and returns a single response. No overlap between warps.
// Optional feature macro: SMEM_WATCHDOG_EN -- aborts a WAIT that lasts
// WDOG_CYCLES cycles and flags rsp_error; without it rsp_error is tied 0.
module smem_warp_sequencer
  import smem_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [LANES-1:0]         req_mask,
  input  logic [LANES*ADDR_W-1:0]  req_addr,
  input  logic [LANES*DATA_W-1:0]  req_data,
  output logic [LANES-1:0]         bank_read,
  output logic [LANES-1:0]         bank_write,
  output logic [LANES*ADDR_W-1:0]  bank_addr,
  output logic [LANES*DATA_W-1:0]  bank_wdata,
  input  logic [LANES-1:0]         bank_finish,
  input  logic [LANES*DATA_W-1:0]  bank_rdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [LANES*DATA_W-1:0]  rsp_data,
  output logic                     rsp_error
);

  state_t                    state_r;
  logic                      write_r;
  logic [LANES*ADDR_W-1:0]   addr_r;
  logic [LANES*DATA_W-1:0]   data_r;
  logic [LANES-1:0]          pending_s;
  logic                      accept_s;
  logic                      in_wait_s;
  logic                      done_s;
  logic                      abort_s;

  assign accept_s  = (state_r == S_IDLE) && req_valid;
  assign in_wait_s = (state_r == S_WAIT);
  assign done_s    = ~any_lane(pending_s & ~bank_finish);

`ifdef SMEM_WATCHDOG_EN
  logic [7:0] wdog_r;
  logic       rsp_error_r;

  assign abort_s = in_wait_s && !done_s && (wdog_r == 8'(WDOG_CYCLES - 1));

  // Watchdog counts WAIT cycles, restarting whenever a new warp is accepted
  always_ff @(posedge clock) begin
    if (reset) begin
      wdog_r <= 8'd0;
    end else if (accept_s) begin
      wdog_r <= 8'd0;
    end else if (in_wait_s) begin
      wdog_r <= wdog_r + 8'd1;
    end else begin
      wdog_r <= wdog_r;
    end
  end

  // Error flag set by a watchdog abort and cleared once the response is taken
  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_error_r <= 1'b0;
    end else if (abort_s) begin
      rsp_error_r <= 1'b1;
    end else if ((state_r == S_RESP) && rsp_ready) begin
      rsp_error_r <= 1'b0;
    end else begin
      rsp_error_r <= rsp_error_r;
    end
  end

  assign rsp_error = rsp_error_r;
`else
  assign abort_s   = 1'b0;
  assign rsp_error = 1'b0;
`endif

  // Warp FSM and request latches: IDLE -> WAIT -> RESP -> IDLE (empty mask skips WAIT)
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= S_IDLE;
      write_r <= 1'b0;
      addr_r  <= {(LANES*ADDR_W){1'b0}};
      data_r  <= {(LANES*DATA_W){1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (req_valid) begin
            write_r <= req_write;
            addr_r  <= req_addr;
            data_r  <= req_data;
            state_r <= any_lane(req_mask) ? S_WAIT : S_RESP;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (done_s || abort_s) begin
            state_r <= S_RESP;
          end else begin
            state_r <= S_WAIT;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state_r <= S_IDLE;
          end else begin
            state_r <= S_RESP;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    smem_lane_tracker u_lane (
      .clock       (clock),
      .reset       (reset),
      .accept      (accept_s),
      .lane_en     (req_mask[g]),
      .is_write    (write_r),
      .in_wait     (in_wait_s),
      .abort       (abort_s),
      .finish      (bank_finish[g]),
      .rdata       (bank_rdata[g*DATA_W +: DATA_W]),
      .pending     (pending_s[g]),
      .read_level  (bank_read[g]),
      .write_level (bank_write[g]),
      .captured    (rsp_data[g*DATA_W +: DATA_W])
    );
  end

  assign req_ready  = (state_r == S_IDLE);
  assign rsp_valid  = (state_r == S_RESP);
  assign bank_addr  = addr_r;
  assign bank_wdata = data_r;

endmodule
